audio_frontend: RTL and testbench
=================================

AUDIO_FRONTEND -- requirements
Module: audio_frontend

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample width in bits, signed two's complement.
REQ-002 SHALL have parameter AVG_LOG2, default 10, meaning log2 of the number of samples averaged per calibration.
REQ-003 SHALL have parameter DECIM_LOG2, default 1, meaning log2 of the decimation factor; 0 means no decimation.
REQ-004 SHALL have parameter LEAK_SHIFT, default 12, meaning the tracking-filter shift.
REQ-005 SHALL have port audio_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port offset_trigger, input, 1 bit: single-cycle request to start calibration.
REQ-008 SHALL have port track_en, input, 1 bit: enables continuous offset tracking in READY.
REQ-009 SHALL have port audio_valid_in, input, 1 bit: single-cycle strobe qualifying audio_in.
REQ-010 SHALL have port audio_in, input, WIDTH bits, signed: raw sample.
REQ-011 SHALL have port audio_out, output, WIDTH bits, signed: corrected, decimated sample, held between strobes.
REQ-012 SHALL have port audio_valid_out, output, 1 bit: single-cycle strobe qualifying audio_out.
REQ-013 SHALL have port offset_out, output, WIDTH bits, signed: offset currently subtracted.
REQ-014 SHALL have port offset_valid, output, 1 bit: high once any calibration has completed.
REQ-015 SHALL have port busy, output, 1 bit: high while in state CAL.

Function
REQ-016 SHALL implement FSM states IDLE, CAL and READY.
REQ-017 SHALL leave IDLE for CAL on offset_trigger, and leave READY for CAL on offset_trigger.
REQ-018 SHALL, on offset_trigger in CAL, restart calibration.
REQ-019 SHALL, on entry to CAL, clear the accumulator and sample count; a sample strobed in the trigger cycle is not accumulated.
REQ-020 SHALL, in CAL, add each valid sample, sign-extended to WIDTH+AVG_LOG2 bits, to the accumulator.
REQ-021 SHALL, on the 2^AVG_LOG2-th valid sample in CAL, register offset_out = (acc+sample)>>>AVG_LOG2 (arithmetic, floor), set offset_valid=1, and go to READY.
REQ-022 SHALL, during CAL, keep subtracting the previous offset_out (0 if never calibrated).
REQ-023 SHALL hold a tracking register T of WIDTH+LEAK_SHIFT bits, loaded with offset<<LEAK_SHIFT on calibration completion.
REQ-024 SHALL, in READY with track_en=1, on each valid sample update T <= T + sample - (T>>>LEAK_SHIFT) and offset_out <= new T>>>LEAK_SHIFT.
REQ-025 SHALL, with track_en=0, hold offset_out constant.
REQ-026 SHALL, as pipeline stage 1, compute the corrected sample c = sat(audio_in - offset_out) in the cycle after audio_valid_in; the subtraction is WIDTH+1 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 SHALL, for c, use offset_out as registered in the cycle audio_valid_in is high, before any update caused by that same sample.
REQ-028 SHALL, as the decimator, accumulate c over 2^DECIM_LOG2 consecutive valid samples using a phase counter that wraps to 0.
REQ-029 SHALL, on the last phase, register audio_out = (sum+c)>>>DECIM_LOG2 and pulse audio_valid_out.
REQ-030 SHALL have a latency of 2 cycles from the audio_valid_in of the group's last sample to audio_valid_out.
REQ-031 SHALL, with DECIM_LOG2=0, output every corrected sample with 2-cycle latency.
REQ-032 SHALL leave the decimator phase and sum unaffected by offset_trigger.
REQ-033 SHALL tolerate back-to-back audio_valid_in on consecutive cycles without loss.

Reset
REQ-034 SHALL, on rst_in, return to state IDLE.
REQ-035 SHALL, on rst_in, clear audio_out, audio_valid_out, offset_out, offset_valid, busy, T, the accumulators, the counters and the pipeline valids.
REQ-036 SHALL give rst_in priority over offset_trigger and audio_valid_in.
REQ-037 SHALL, on rst_in during CAL, discard the calibration in progress.

Verification
REQ-038 SHALL cover: assert rst_in mid-CAL -> all outputs 0, busy=0, next samples pass uncorrected.
REQ-039 SHALL cover: AVG_LOG2=2; trigger, then 4 samples of -1000 -> offset_out=-1000, offset_valid=1, busy falls; subsequent samples of -1000 -> audio_out=0.
REQ-040 SHALL cover: saturation; WIDTH=16, offset +1000, sample -32768 -> c=-32768; offset -1000, sample 32767 -> c=32767.
REQ-041 SHALL cover: DECIM_LOG2=1, offset 0; samples 100, 300, 500, 700 -> audio_out 200 then 600, each strobe exactly 2 cycles after the 2nd and 4th inputs.
REQ-042 SHALL cover: AVG_LOG2=2; 2 samples of 900, retrigger, then 4 samples of 40 -> offset_out=40.
REQ-043 SHALL cover: LEAK_SHIFT=2, calibrated offset 0, track_en=1, constant samples of 400 -> offset_out sequence 100, 175, 231.

Source files
------------

// File: rtl/audio_frontend.sv
// Audio front end: offset calibration by block averaging, optional leaky offset
// tracking, saturating offset removal and power-of-two averaging decimation.
module audio_frontend #(
  parameter int WIDTH      = 16,
  parameter int AVG_LOG2   = 10,
  parameter int DECIM_LOG2 = 1,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    offset_trigger,
  input  logic                    track_en,
  input  logic                    audio_valid_in,
  input  logic signed [WIDTH-1:0] audio_in,
  output logic signed [WIDTH-1:0] audio_out,
  output logic                    audio_valid_out,
  output logic signed [WIDTH-1:0] offset_out,
  output logic                    offset_valid,
  output logic                    busy
);

  localparam int AW = WIDTH + AVG_LOG2;
  localparam int TW = WIDTH + LEAK_SHIFT;
  localparam int TX = TW + 1;
  localparam int SW = WIDTH + DECIM_LOG2;
  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'((1 << AVG_LOG2) - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, READY = 2'd2} state_t;

  state_t state, state_next;

  logic signed [AW-1:0]    acc;
  logic        [CW-1:0]    cnt;
  logic signed [TW-1:0]    trk;
  logic signed [WIDTH-1:0] corr;
  logic                    corr_valid;
  logic signed [SW-1:0]    dsum;
  logic        [PW-1:0]    phase;

  logic                    cal_sample;
  logic                    cal_done;
  logic                    track_sample;
  logic signed [AW-1:0]    acc_sum;
  logic signed [AW-1:0]    acc_shift;
  logic signed [WIDTH-1:0] cal_avg;
  logic signed [TW-1:0]    trk_shift;
  logic signed [TX-1:0]    trk_sum;
  logic signed [TW-1:0]    trk_new;
  logic signed [TW-1:0]    trk_new_shift;
  logic signed [WIDTH-1:0] track_off;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] sat_c;
  logic signed [SW-1:0]    dsum_total;
  logic signed [SW-1:0]    dec_shift;

  // The trigger cycle only restarts calibration, so its sample is not averaged.
  assign cal_sample   = (state == CAL) && audio_valid_in && !offset_trigger;
  assign cal_done     = cal_sample && (cnt == CNT_LAST);
  assign track_sample = (state == READY) && track_en && audio_valid_in && !offset_trigger;

  always_comb begin
    acc_sum       = acc + AW'(audio_in);
    acc_shift     = acc_sum >>> AVG_LOG2;
    cal_avg       = acc_shift[WIDTH-1:0];
    trk_shift     = trk >>> LEAK_SHIFT;
    trk_sum       = TX'(trk) + TX'(audio_in) - TX'(trk_shift);
    trk_new       = trk_sum[TW-1:0];
    trk_new_shift = trk_new >>> LEAK_SHIFT;
    track_off     = trk_new_shift[WIDTH-1:0];
    diff          = (WIDTH+1)'(audio_in) - (WIDTH+1)'(offset_out);
    // Disagreeing top bits mean the difference left the WIDTH-bit range.
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat_c = diff[WIDTH] ? S_MIN : S_MAX;
    end else begin
      sat_c = diff[WIDTH-1:0];
    end
    dsum_total = dsum + SW'(corr);
    dec_shift  = dsum_total >>> DECIM_LOG2;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (offset_trigger) state_next = CAL;
      CAL:     if (offset_trigger) state_next = CAL;
               else if (cal_done) state_next = READY;
      READY:   if (offset_trigger) state_next = CAL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state        <= IDLE;
      busy         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      trk          <= '0;
      offset_out   <= '0;
      offset_valid <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CAL);
      if (offset_trigger) begin
        acc <= '0;
        cnt <= '0;
      end else if (cal_sample) begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
        if (cal_done) begin
          offset_out   <= cal_avg;
          offset_valid <= 1'b1;
          trk          <= TW'(cal_avg) <<< LEAK_SHIFT;
        end
      end else if (track_sample) begin
        trk        <= trk_new;
        offset_out <= track_off;
      end
    end
  end

  // Stage 1 uses the offset as registered before this sample can update it.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      corr       <= '0;
      corr_valid <= 1'b0;
    end else begin
      corr_valid <= audio_valid_in;
      if (audio_valid_in) begin
        corr <= sat_c;
      end
    end
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      dsum            <= '0;
      phase           <= '0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      audio_valid_out <= 1'b0;
      if (corr_valid) begin
        if (phase == PHASE_LAST) begin
          audio_out       <= dec_shift[WIDTH-1:0];
          audio_valid_out <= 1'b1;
          dsum            <= '0;
          phase           <= '0;
        end else begin
          dsum  <= dsum_total;
          phase <= phase + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_frontend.sv
// Self-checking bench for audio_frontend: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_audio_frontend;

  localparam int W  = 16;
  localparam int AL = 2;
  localparam int DL = 1;
  localparam int LS = 2;
  localparam longint AN = 64'd1 << AL;
  localparam longint DN = 64'd1 << DL;
  localparam longint LN = 64'd1 << LS;

  logic                audio_clk = 1'b0;
  logic                rst_in = 1'b0;
  logic                offset_trigger = 1'b0;
  logic                track_en = 1'b0;
  logic                audio_valid_in = 1'b0;
  logic signed [W-1:0] audio_in = '0;
  logic signed [W-1:0] audio_out;
  logic                audio_valid_out;
  logic signed [W-1:0] offset_out;
  logic                offset_valid;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: mode 0 idle, 1 calibrating, 2 calibrated.
  int     m_mode;
  longint m_off, m_T, m_acc, m_cnt, m_c, m_dsum, m_phase, m_out;
  bit     m_oval, m_cv, m_vout;

  audio_frontend #(.WIDTH(W), .AVG_LOG2(AL), .DECIM_LOG2(DL), .LEAK_SHIFT(LS)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .offset_trigger(offset_trigger),
    .track_en(track_en), .audio_valid_in(audio_valid_in), .audio_in(audio_in),
    .audio_out(audio_out), .audio_valid_out(audio_valid_out),
    .offset_out(offset_out), .offset_valid(offset_valid), .busy(busy)
  );

  always #5 audio_clk = ~audio_clk;

  function automatic longint floordiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit k, input bit v, input longint s);
    if (r) begin
      m_mode = 0; m_off = 0; m_oval = 0; m_T = 0; m_acc = 0; m_cnt = 0;
      m_cv = 0; m_c = 0; m_dsum = 0; m_phase = 0; m_out = 0; m_vout = 0;
      return;
    end
    m_vout = 0;
    if (m_cv) begin
      if (m_phase == DN - 1) begin
        m_out = floordiv(m_dsum + m_c, DN); m_vout = 1; m_dsum = 0; m_phase = 0;
      end else begin
        m_dsum = m_dsum + m_c; m_phase = m_phase + 1;
      end
    end
    m_cv = v;
    if (v) m_c = sat(s - m_off);
    if (t) begin
      m_mode = 1; m_acc = 0; m_cnt = 0;
    end else if (m_mode == 1 && v) begin
      m_acc = m_acc + s; m_cnt = m_cnt + 1;
      if (m_cnt == AN) begin
        m_off = floordiv(m_acc, AN); m_oval = 1; m_T = m_off * LN; m_mode = 2;
      end
    end else if (m_mode == 2 && k && v) begin
      m_T = m_T + s - floordiv(m_T, LN);
      m_off = floordiv(m_T, LN);
    end
  endtask

  task automatic tick(input bit r, input bit t, input bit k, input bit v, input int s);
    rst_in = r; offset_trigger = t; track_en = k; audio_valid_in = v; audio_in = W'(s);
    model_step(r, t, k, v, longint'(s));
    @(posedge audio_clk);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 0);
    n_checks++; if (audio_out !== 16'sd0) begin n_fail++; $display("FAIL reset_audio_out got %0d expected 0", audio_out); end
    n_checks++; if (audio_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out got %0b expected 0", audio_valid_out); end
    n_checks++; if (offset_out !== 16'sd0) begin n_fail++; $display("FAIL reset_offset got %0d expected 0", offset_out); end
    n_checks++; if (offset_valid !== 1'b0) begin n_fail++; $display("FAIL reset_offset_valid got %0b expected 0", offset_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b expected 0", busy); end
  endtask

  task automatic test_cal_negative;
    int strobes;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cal_busy_rise got %0b expected 1", busy); end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, -1000);
    n_checks++; if (offset_out !== -16'sd1000) begin n_fail++; $display("FAIL cal_offset got %0d expected -1000", offset_out); end
    n_checks++; if (offset_valid !== 1'b1) begin n_fail++; $display("FAIL cal_offset_valid got %0b expected 1", offset_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cal_busy_fall got %0b expected 0", busy); end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, (i < 4) ? 1'b1 : 1'b0, -1000);
      if (audio_valid_out) begin
        strobes++;
        n_checks++; if (audio_out !== 16'sd0) begin n_fail++; $display("FAIL cal_corrected got %0d expected 0", audio_out); end
      end
    end
    n_checks++; if (strobes != 2) begin n_fail++; $display("FAIL cal_strobes got %0d expected 2", strobes); end
  endtask

  task automatic test_saturation;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1000);
    tick(0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, -32768); tick(0, 0, 0, 1, -32768); tick(0, 0, 0, 0, 0);
    n_checks++; if (audio_valid_out !== 1'b1 || audio_out !== -16'sd32768) begin
      n_fail++; $display("FAIL sat_low got %0d/%0b expected -32768/1", audio_out, audio_valid_out); end
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, -1000);
    tick(0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 32767); tick(0, 0, 0, 1, 32767); tick(0, 0, 0, 0, 0);
    n_checks++; if (audio_valid_out !== 1'b1 || audio_out !== 16'sd32767) begin
      n_fail++; $display("FAIL sat_high got %0d/%0b expected 32767/1", audio_out, audio_valid_out); end
  endtask

  task automatic test_reset_mid_cal;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 500);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 900); tick(0, 0, 0, 1, 900);
    tick(1, 0, 0, 1, 900);
    n_checks++; if (busy !== 1'b0 || offset_valid !== 1'b0 || offset_out !== 16'sd0) begin
      n_fail++; $display("FAIL midcal_reset got busy=%0b oval=%0b off=%0d expected 0/0/0", busy, offset_valid, offset_out); end
    n_checks++; if (audio_out !== 16'sd0 || audio_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL midcal_audio got %0d/%0b expected 0/0", audio_out, audio_valid_out); end
    tick(0, 0, 0, 1, 100); tick(0, 0, 0, 1, 300); tick(0, 0, 0, 0, 0);
    n_checks++; if (audio_valid_out !== 1'b1 || audio_out !== 16'sd200) begin
      n_fail++; $display("FAIL midcal_uncorrected got %0d/%0b expected 200/1", audio_out, audio_valid_out); end
  endtask

  task automatic test_decimation;
    int ins[4] = '{100, 300, 500, 700};
    bit exp_v[6] = '{0, 0, 1, 0, 1, 0};
    int exp_o[6] = '{0, 0, 200, 0, 600, 0};
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, (i < 4) ? 1'b1 : 1'b0, (i < 4) ? ins[i] : 0);
      n_checks++; if (audio_valid_out !== exp_v[i]) begin
        n_fail++; $display("FAIL decim_strobe[%0d] got %0b expected %0b", i, audio_valid_out, exp_v[i]); end
      if (exp_v[i]) begin
        n_checks++; if (audio_out !== W'(exp_o[i])) begin
          n_fail++; $display("FAIL decim_value[%0d] got %0d expected %0d", i, audio_out, exp_o[i]); end
      end
    end
  endtask

  task automatic test_retrigger;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 900); tick(0, 0, 0, 1, 900);
    n_checks++; if (busy !== 1'b1 || offset_valid !== 1'b0) begin
      n_fail++; $display("FAIL retrig_partial got busy=%0b oval=%0b expected 1/0", busy, offset_valid); end
    tick(0, 1, 0, 1, 900);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 40);
    n_checks++; if (offset_out !== 16'sd40 || offset_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL retrig_offset got %0d/%0b/%0b expected 40/1/0", offset_out, offset_valid, busy); end
  endtask

  task automatic test_tracking;
    int exp_off[3] = '{100, 175, 231};
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 1, 400);
      n_checks++; if (offset_out !== W'(exp_off[i])) begin
        n_fail++; $display("FAIL track[%0d] got %0d expected %0d", i, offset_out, exp_off[i]); end
    end
    tick(0, 0, 0, 1, 400); tick(0, 0, 0, 1, -400);
    n_checks++; if (offset_out !== 16'sd231) begin
      n_fail++; $display("FAIL track_hold got %0d expected 231", offset_out); end
  endtask

  task automatic test_random;
    bit r, t, k, v;
    int s;
    tick(1, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) k = ~k;
      v = ($urandom_range(0, 3) != 0);
      s = (i % 3 == 0) ? ($urandom_range(0, 65535) - 32768) : ($urandom_range(0, 4000) - 2000);
      tick(r, t, k, v, s);
      n_checks++; if (audio_valid_out !== m_vout) begin
        n_fail++; $display("FAIL rnd_valid_out cyc %0d got %0b expected %0b", i, audio_valid_out, m_vout); end
      n_checks++; if (audio_out !== W'(m_out)) begin
        n_fail++; $display("FAIL rnd_audio_out cyc %0d got %0d expected %0d", i, audio_out, m_out); end
      n_checks++; if (offset_out !== W'(m_off)) begin
        n_fail++; $display("FAIL rnd_offset cyc %0d got %0d expected %0d", i, offset_out, m_off); end
      n_checks++; if (offset_valid !== m_oval || busy !== (m_mode == 1)) begin
        n_fail++; $display("FAIL rnd_flags cyc %0d got oval=%0b busy=%0b expected %0b/%0b", i, offset_valid, busy, m_oval, m_mode == 1); end
    end
  endtask

  initial begin
    @(posedge audio_clk);
    #1;
    test_reset();
    test_cal_negative();
    test_saturation();
    test_reset_mid_cal();
    test_decimation();
    test_retrigger();
    test_tracking();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
